mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Owns the single byte-wide RAM port and shares it between instruction fetch (IF) and the load/store buffer (LS).
Accepts one 1/2/4-byte request at a time, serialises it into byte accesses and assembles read data little-endian.
Returns a one-cycle ok pulse to the granted requester.
Handles misprediction flush and the IO output-buffer back-pressure.

Parameters:
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region (0x30000+).

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; low freezes all state
clear  in  1  flush pulse from ROB on mispredict
if_req  in  1  fetch request, held until if_ok
if_addr  in  32  fetch address (word)
if_ok  out  1  fetch done pulse
if_data  out  32  fetched instruction, valid with if_ok
ls_req  in  1  load/store request, held until ls_ok
ls_we  in  1  1 = store
ls_size  in  2  0 = byte, 1 = half, 2 = word
ls_addr  in  32  byte address
ls_wdata  in  32  store data, low bytes used
ls_ok  out  1  done pulse
ls_rdata  out  32  load data, zero-extended (LS does sign extension), valid with ls_ok
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  RAM write enable
io_buffer_full  in  1  IO sink cannot accept a byte

Behaviour:
- rst is synchronous and active-high; clk is the clock.
- Reset values: all outputs 0; state IDLE; last_grant = IF.
- States:
  - IDLE: accepts a new request.
  - READ: issues and captures bytes.
  - WRITE: drives bytes.
  - IO_WAIT: store to IO region while io_buffer_full is high.
- Arbitration, sampled in IDLE only:
  - Only one requester high: grant it.
  - Both high: grant the one not granted last.
  - At reset, LS wins ties.
  - The grant latches addr, size (IF is always size 2), we and wdata.
  - A req that is high during its own ok cycle is ignored; the requester drops req then.
- Byte count N = 1/2/4. Request accepted at edge 0:
  - Read: mem_a = addr+i registered at edge i+1, i = 0..N-1. mem_din for byte i is sampled at edge i+2 into bits [8i+7:8i]. ok and data registered at edge N+2 (word read: ok high in cycle 6).
  - Write: mem_a = addr+i, mem_dout = wdata byte i, mem_wr = 1 registered at edge i+1. At edge N+1, mem_wr = 0 and ok = 1.
- IO write: before each byte, if addr[17:16] == IO_ADDR_HI and io_buffer_full = 1, enter IO_WAIT. mem_wr = 0 and the byte index is held until io_buffer_full = 0, then resume. Latency stretches accordingly.
- Outside READ/WRITE: mem_wr = 0 and mem_a = 0.
- ok outputs are single-cycle pulses. Data outputs hold their value until the next ok.
- clear (takes priority over normal progress):
  - If the grant is IF, or a LS read: abort. Next edge IDLE, no ok, mem_wr = 0.
  - If the grant is a LS write: no effect; the write completes and pulses ls_ok, because stores are committed.
  - clear in IDLE blocks acceptance that cycle.
- rdy = 0: state, counters and outputs hold; mem_wr forced 0 and re-asserted when rdy returns.
- Address arithmetic is 32-bit wrap. No misalignment checks.
- Only one transaction is in flight. There is no internal request queue.

Decomposition:
- Shared defines file:
  - state encodings (IDLE/READ/WRITE/IO_WAIT)
  - ls_size encodings (SZ_B/SZ_H/SZ_W)
  - IO_ADDR_HI
  - requester IDs (GNT_IF/GNT_LS)
- Single module; no sub-module needed.

Test Plan:
- IF word read at 0x100, RAM bytes 13 05 00 00 -> mem_a 0x100..0x103 on edges 1..4; if_ok in cycle 6 with if_data = 0x00000513.
- LS sh: addr 0x204, wdata 0xABCD1234 -> mem_wr = 1 for two cycles with (0x204, 0x34), (0x205, 0x12); ls_ok at edge 3; mem_wr = 0 after.
- if_req and ls_req both held continuously -> grants alternate LS, IF, LS, IF. Each ok is a single pulse and neither requester starves.
- sb to 0x30000 with io_buffer_full = 1 for 5 cycles -> mem_wr stays 0 for those cycles; byte written in the first cycle after release; ls_ok one edge later.
- clear at edge 2 of an IF read -> no if_ok; IDLE next; a pending LS request is accepted on the following edge.
- clear during an LS sw -> all 4 bytes written and ls_ok still pulses.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM port arbiter: FSM states, access
// sizes, requester IDs and the IO region marker.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_IO_WAIT = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the load/store
// buffer; serialises 1/2/4-byte requests and assembles reads little-endian.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ok,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ok,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state_q, state_d;
    gnt_e        gnt_q, gnt_d;
    gnt_e        last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_ok_q, if_ok_d;
    logic        ls_ok_q, ls_ok_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic eff_if, eff_ls, pick_ls, is_io;

    // A requester still sees its own ok this cycle, so its held req is stale.
    assign eff_if = if_req & ~if_ok_q;
    assign eff_ls = ls_req & ~ls_ok_q;
    assign is_io  = (addr_q[17:16] == IO_ADDR_HI);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = 32'd0;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        if_ok_d    = 1'b0;
        ls_ok_d    = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        pick_ls    = eff_ls && (!eff_if || last_q == GNT_IF);

        case (state_q)
            ST_IDLE: begin
                if (!clear && (eff_if || eff_ls)) begin
                    cnt_d  = 3'd0;
                    rbuf_d = 32'd0;
                    if (pick_ls) begin
                        gnt_d    = GNT_LS;
                        addr_d   = ls_addr;
                        nbytes_d = size_bytes(ls_size);
                        we_d     = ls_we;
                        wdata_d  = ls_wdata;
                        state_d  = ls_we ? ST_WRITE : ST_READ;
                    end else begin
                        gnt_d    = GNT_IF;
                        addr_d   = if_addr;
                        nbytes_d = size_bytes(SZ_W);
                        we_d     = 1'b0;
                        wdata_d  = 32'd0;
                        state_d  = ST_READ;
                    end
                    last_d = gnt_d;
                end
            end
            ST_READ: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q < nbytes_q)
                        mem_a_d = addr_q + {29'd0, cnt_q};
                    // RAM data lags its address by one cycle.
                    if (cnt_q != 3'd0 && cnt_q <= nbytes_q)
                        rbuf_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
                    if (cnt_q == nbytes_q + 3'd1) begin
                        state_d = ST_IDLE;
                        if (gnt_q == GNT_IF) begin
                            if_ok_d   = 1'b1;
                            if_data_d = rbuf_q;
                        end else begin
                            ls_ok_d    = 1'b1;
                            ls_rdata_d = rbuf_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            // Stores are already committed, so clear never interrupts them.
            ST_WRITE, ST_IO_WAIT: begin
                if (cnt_q >= nbytes_q) begin
                    ls_ok_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (is_io && io_buffer_full) begin
                    state_d = ST_IO_WAIT;
                end else begin
                    mem_a_d    = addr_q + {29'd0, cnt_q};
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                    state_d    = ST_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_IF;
            last_q     <= GNT_IF;
            cnt_q      <= 3'd0;
            nbytes_q   <= 3'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_ok_q    <= 1'b0;
            ls_ok_q    <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else if (rdy) begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_ok_q    <= if_ok_d;
            ls_ok_q    <= ls_ok_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Pulses are masked while frozen so a stall never duplicates a write or an ok.
    assign mem_wr   = mem_wr_q & rdy;
    assign if_ok    = if_ok_q & rdy;
    assign ls_ok    = ls_ok_q & rdy;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a combinational RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ok;
    logic [31:0] if_data;
    logic        ls_req, ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ok;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0] ram [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ok(ls_ok), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[9:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0;
        ls_addr = 0; ls_wdata = 0; clear = 0; io_buffer_full = 0; rdy = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        n_tests++;
        if ({if_ok, ls_ok, mem_wr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses got %b want 000", {if_ok, ls_ok, mem_wr});
        end
        n_tests++;
        if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin
            n_fail++; $display("FAIL reset_mem got a=%h dout=%h want 0/0", mem_a, mem_dout);
        end
        n_tests++;
        if (if_data !== 32'd0 || ls_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_data got %h/%h want 0/0", if_data, ls_rdata);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_if_read();
        if_req = 1; if_addr = 32'h100;
        tick();                                   // edge 0: accept
        for (int i = 0; i < 4; i++) begin
            tick();                               // edge i+1
            n_tests++;
            if (mem_a !== 32'h100 + i || mem_wr !== 1'b0) begin
                n_fail++; $display("FAIL if_read_addr%0d got a=%h wr=%b want %h/0", i, mem_a, mem_wr, 32'h100 + i);
            end
        end
        tick();                                   // edge 5
        n_tests++;
        if (if_ok !== 1'b0) begin
            n_fail++; $display("FAIL if_read_early_ok got %b want 0", if_ok);
        end
        tick();                                   // edge 6
        n_tests++;
        if (if_ok !== 1'b1 || if_data !== 32'h00000513) begin
            n_fail++; $display("FAIL if_read_ok got ok=%b data=%h want 1/00000513", if_ok, if_data);
        end
        if_req = 0;
        tick();
        n_tests++;
        if (if_ok !== 1'b0 || if_data !== 32'h00000513) begin
            n_fail++; $display("FAIL if_read_hold got ok=%b data=%h want 0/00000513", if_ok, if_data);
        end
    endtask

    task automatic test_ls_store_half();
        ls_req = 1; ls_we = 1; ls_size = 2'd1; ls_addr = 32'h204; ls_wdata = 32'hABCD1234;
        tick();                                   // edge 0
        tick();                                   // edge 1
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h204 || mem_dout !== 8'h34 || ls_ok !== 1'b0) begin
            n_fail++; $display("FAIL sh_byte0 got wr=%b a=%h d=%h ok=%b want 1/204/34/0", mem_wr, mem_a, mem_dout, ls_ok);
        end
        tick();                                   // edge 2
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h205 || mem_dout !== 8'h12) begin
            n_fail++; $display("FAIL sh_byte1 got wr=%b a=%h d=%h want 1/205/12", mem_wr, mem_a, mem_dout);
        end
        tick();                                   // edge 3
        n_tests++;
        if (ls_ok !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL sh_ok got ok=%b wr=%b want 1/0", ls_ok, mem_wr);
        end
        ls_req = 0; ls_we = 0;
        tick();
        n_tests++;
        if (ls_ok !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL sh_after got ok=%b wr=%b want 0/0", ls_ok, mem_wr);
        end
    endtask

    task automatic test_ls_load_half();
        ls_req = 1; ls_we = 0; ls_size = 2'd1; ls_addr = 32'h10;
        tick();                                   // edge 0
        tick(); tick(); tick();                   // edges 1..3
        n_tests++;
        if (ls_ok !== 1'b0) begin
            n_fail++; $display("FAIL lh_early_ok got %b want 0", ls_ok);
        end
        tick();                                   // edge 4 = N+2
        n_tests++;
        if (ls_ok !== 1'b1 || ls_rdata !== 32'h0000FF80) begin
            n_fail++; $display("FAIL lh_ok got ok=%b data=%h want 1/0000ff80", ls_ok, ls_rdata);
        end
        ls_req = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        int got = 0;
        int dup = 0;
        logic prev_if = 0, prev_ls = 0;
        rst = 1; tick(); rst = 0;
        ls_req = 1; ls_we = 0; ls_size = 2'd0; ls_addr = 32'h10;
        if_req = 1; if_addr = 32'h100;
        seq = 4'b0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            tick();
            if ((if_ok && prev_if) || (ls_ok && prev_ls) || (if_ok && ls_ok)) dup++;
            prev_if = if_ok; prev_ls = ls_ok;
            if (ls_ok) begin
                seq[got] = 1'b1; got++;
                n_tests++;
                if (ls_rdata !== 32'h00000080) begin
                    n_fail++; $display("FAIL b2b_ls_data got %h want 00000080", ls_rdata);
                end
            end else if (if_ok) begin
                seq[got] = 1'b0; got++;
                n_tests++;
                if (if_data !== 32'h00000513) begin
                    n_fail++; $display("FAIL b2b_if_data got %h want 00000513", if_data);
                end
            end
        end
        n_tests++;
        if (got != 4) begin
            n_fail++; $display("FAIL b2b_count got %0d grants want 4 within budget", got);
        end
        n_tests++;
        if (seq !== 4'b0101) begin
            n_fail++; $display("FAIL b2b_order got %b want 0101 (bit0 first, 1=LS)", seq);
        end
        n_tests++;
        if (dup != 0) begin
            n_fail++; $display("FAIL b2b_pulse got %0d stretched/overlapping oks want 0", dup);
        end
        if_req = 0; ls_req = 0;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_clear_if();
        int bad_ok = 0;
        if_req = 1; if_addr = 32'h100;
        tick();                                   // edge 0: IF accepted alone
        ls_req = 1; ls_we = 0; ls_size = 2'd0; ls_addr = 32'h10;
        tick();                                   // edge 1
        clear = 1;
        tick();                                   // edge 2: abort
        clear = 0; if_req = 0;
        n_tests++;
        if (mem_a !== 32'd0 || if_ok !== 1'b0) begin
            n_fail++; $display("FAIL clr_abort got a=%h ok=%b want 0/0", mem_a, if_ok);
        end
        tick();                                   // edge 3: LS accepted
        tick();                                   // edge 4
        n_tests++;
        if (mem_a !== 32'h10) begin
            n_fail++; $display("FAIL clr_ls_addr got %h want 00000010", mem_a);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            if (if_ok) bad_ok++;
        end                                       // now at edge 6
        n_tests++;
        if (ls_ok !== 1'b1 || ls_rdata !== 32'h80 || bad_ok != 0) begin
            n_fail++; $display("FAIL clr_ls_ok got ok=%b data=%h if_oks=%0d want 1/80/0", ls_ok, ls_rdata, bad_ok);
        end
        ls_req = 0;
        tick();
    endtask

    task automatic test_clear_store();
        logic [7:0] exp_b;
        logic [31:0] wd;
        wd = 32'h11223344;
        ls_req = 1; ls_we = 1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = wd;
        tick();                                   // edge 0
        clear = 1;
        for (int i = 0; i < 4; i++) begin
            tick();                               // edge i+1
            if (i == 1) clear = 0;
            exp_b = wd[8*i +: 8];
            n_tests++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h300 + i || mem_dout !== exp_b) begin
                n_fail++; $display("FAIL sw_clr_byte%0d got wr=%b a=%h d=%h want 1/%h/%h", i, mem_wr, mem_a, mem_dout, 32'h300 + i, exp_b);
            end
        end
        tick();                                   // edge 5
        n_tests++;
        if (ls_ok !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL sw_clr_ok got ok=%b wr=%b want 1/0", ls_ok, mem_wr);
        end
        ls_req = 0; ls_we = 0;
        tick();
    endtask

    task automatic test_io_wait();
        int wr_seen = 0;
        ls_req = 1; ls_we = 1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h5A;
        io_buffer_full = 1;
        tick();                                   // edge 0
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_wr) wr_seen++;
        end
        n_tests++;
        if (wr_seen != 0) begin
            n_fail++; $display("FAIL io_blocked got %0d write cycles want 0", wr_seen);
        end
        io_buffer_full = 0;
        tick();
        n_tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h5A || ls_ok !== 1'b0) begin
            n_fail++; $display("FAIL io_release got wr=%b a=%h d=%h ok=%b want 1/30000/5a/0", mem_wr, mem_a, mem_dout, ls_ok);
        end
        tick();
        n_tests++;
        if (ls_ok !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL io_ok got ok=%b wr=%b want 1/0", ls_ok, mem_wr);
        end
        ls_req = 0; ls_we = 0;
        tick();
    endtask

    task automatic test_rdy_freeze();
        ls_req = 1; ls_we = 1; ls_size = 2'd0; ls_addr = 32'h400; ls_wdata = 32'h77;
        tick();                                   // edge 0
        tick();                                   // edge 1: byte driven
        rdy = 0;
        #1;
        n_tests++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h400) begin
            n_fail++; $display("FAIL rdy_mask got wr=%b a=%h want 0/400", mem_wr, mem_a);
        end
        tick(); tick();
        n_tests++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h400 || mem_dout !== 8'h77 || ls_ok !== 1'b0) begin
            n_fail++; $display("FAIL rdy_hold got wr=%b a=%h d=%h ok=%b want 0/400/77/0", mem_wr, mem_a, mem_dout, ls_ok);
        end
        rdy = 1;
        #1;
        n_tests++;
        if (mem_wr !== 1'b1) begin
            n_fail++; $display("FAIL rdy_resume got wr=%b want 1", mem_wr);
        end
        tick();
        n_tests++;
        if (ls_ok !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL rdy_ok got ok=%b wr=%b want 1/0", ls_ok, mem_wr);
        end
        ls_req = 0; ls_we = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
        ram[10'h010] = 8'h80; ram[10'h011] = 8'hFF;
        idle_inputs();
        rst = 1;
        test_reset();
        test_if_read();
        test_ls_store_half();
        test_ls_load_half();
        test_back_to_back();
        test_clear_if();
        test_clear_store();
        test_io_wait();
        test_rdy_freeze();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
